// File: rtl/lrelu_config_reader.sv
// rtl/lrelu_config_reader.sv - LeakyReLU configuration RAM read-side sequencer
//
// Replays the loaded configuration table in order once per output block:
// linear RAM read addresses tagged with {clr_i, w_sel}. A 4-entry output
// FIFO absorbs the fixed 2-cycle RAM read latency. Reads are credit
// controlled, so the FIFO cannot overflow. The result is a valid/ready
// stream with last, delivered to the LeakyReLU datapath.
//
// Optional feature macro: LRELU_READER_USER_EN
//   defined   - the {clr_i, w_sel} tag travels with each beat to m_user
//   undefined - no tag storage is built, and m_user is tied to 0
//
// Ports:
//   clk, rstn        clock, synchronous active-low reset
//   full             config table loaded (from the write-side counter)
//   start            begin a replay run (sampled only while idle)
//   kw2              kernel half-width, captured at start, clamped to CLR_I_MAX
//   reps             table replays per run, captured at start (0 acts as 1)
//   r_en, r_addr     RAM read request
//   r_data           RAM read data, valid 2 cycles after r_en
//   m_valid/m_ready  output stream handshake
//   m_data           output beat (one RAM row)
//   m_user           {clr_i, w_sel} of the beat
//   m_last           final beat of the final replay
//   busy             run in progress
//   done             one-cycle pulse after the m_last handshake
module lrelu_config_reader #(
  parameter int MEMBERS      = 12,
  parameter int WORD_W       = 16,
  parameter int KW_MAX       = 3,
  parameter int SEL_N        = 3,
  parameter int ADDR_PER_SEL = 4,
  parameter int REPS_W       = 16,
  parameter int CLR_I_MAX    = KW_MAX / 2,
  parameter int BITS_KW2     = $clog2(KW_MAX / 2 + 1),
  parameter int BITS_CLR_I   = $clog2(CLR_I_MAX + 1),
  parameter int BITS_W_SEL   = $clog2(SEL_N),
  parameter int BITS_R_ADDR  = $clog2((CLR_I_MAX + 1) * SEL_N * ADDR_PER_SEL)
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             full,
  input  logic                             start,
  input  logic [BITS_KW2-1:0]              kw2,
  input  logic [REPS_W-1:0]                reps,
  output logic                             r_en,
  output logic [BITS_R_ADDR-1:0]           r_addr,
  input  logic [MEMBERS*WORD_W-1:0]        r_data,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [MEMBERS*WORD_W-1:0]        m_data,
  output logic [BITS_CLR_I+BITS_W_SEL-1:0] m_user,
  output logic                             m_last,
  output logic                             busy,
  output logic                             done
);

  localparam int DATA_W     = MEMBERS * WORD_W;
  localparam int USER_W     = BITS_CLR_I + BITS_W_SEL;
  localparam int BITS_A     = (ADDR_PER_SEL > 1) ? $clog2(ADDR_PER_SEL) : 1;
  localparam int FIFO_DEPTH = 4;

  localparam logic [BITS_A-1:0]     A_LAST     = BITS_A'(ADDR_PER_SEL - 1);
  localparam logic [BITS_W_SEL-1:0] W_LAST     = BITS_W_SEL'(SEL_N - 1);
  localparam logic [BITS_CLR_I-1:0] CLR_I_LAST = BITS_CLR_I'(CLR_I_MAX);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t state_q, state_d;

  // Run configuration, captured at start
  logic [BITS_CLR_I-1:0]  kw2_q;
  logic [REPS_W-1:0]      reps_last_q;
  logic [BITS_CLR_I-1:0]  kw2_clamped;

  // Issue-side loop counters
  logic [BITS_A-1:0]      a_q;
  logic [BITS_W_SEL-1:0]  w_sel_q;
  logic [BITS_CLR_I-1:0]  clr_i_q;
  logic [REPS_W-1:0]      rep_q;
  logic [BITS_R_ADDR-1:0] addr_q;

  // Read-latency pipe: one stage per RAM cycle
  logic pipe_v1_q, pipe_v2_q;
  logic last1_q, last2_q;

  // Output FIFO
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic              fifo_last [FIFO_DEPTH];
  logic [1:0]        wr_ptr_q, rd_ptr_q;
  logic [2:0]        fifo_count_q;

  logic       start_acc;
  logic       credit_ok;
  logic       issue;
  logic       replay_end;
  logic       issue_last;
  logic       push;
  logic       pop;
  logic [2:0] in_flight;
  logic       done_q;

  assign kw2_clamped = (int'(kw2) > CLR_I_MAX) ? CLR_I_LAST : BITS_CLR_I'(kw2);

  assign start_acc = (state_q == IDLE) && start && full;

  // A read is allowed only when every outstanding read plus every buffered
  // beat still fits in the FIFO. This keeps the FIFO from overflowing even
  // if the consumer stalls indefinitely.
  assign in_flight = {2'b00, pipe_v1_q} + {2'b00, pipe_v2_q};
  assign credit_ok = (in_flight + fifo_count_q) < 3'd4;
  assign issue     = (state_q == RUN) && credit_ok;

  assign replay_end = (a_q == A_LAST) && (w_sel_q == W_LAST) && (clr_i_q == kw2_q);
  assign issue_last = replay_end && (rep_q == reps_last_q);

  assign push = pipe_v2_q;
  assign pop  = m_valid && m_ready;

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_acc) state_d = RUN;
      RUN:     if (issue && issue_last) state_d = DRAIN;
      DRAIN:   if (pop && m_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address and tag counters: row innermost, then w_sel, then clr_i.
  // The linear address wraps to 0 at every replay boundary.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      kw2_q       <= '0;
      reps_last_q <= '0;
      a_q         <= '0;
      w_sel_q     <= '0;
      clr_i_q     <= '0;
      rep_q       <= '0;
      addr_q      <= '0;
    end else if (start_acc) begin
      kw2_q       <= kw2_clamped;
      reps_last_q <= (reps == '0) ? '0 : reps - 1'b1;
      a_q         <= '0;
      w_sel_q     <= '0;
      clr_i_q     <= '0;
      rep_q       <= '0;
      addr_q      <= '0;
    end else if (issue) begin
      addr_q <= replay_end ? '0 : addr_q + 1'b1;
      if (a_q != A_LAST) begin
        a_q <= a_q + 1'b1;
      end else begin
        a_q <= '0;
        if (w_sel_q != W_LAST) begin
          w_sel_q <= w_sel_q + 1'b1;
        end else begin
          w_sel_q <= '0;
          if (clr_i_q != kw2_q) begin
            clr_i_q <= clr_i_q + 1'b1;
          end else begin
            clr_i_q <= '0;
            rep_q   <= rep_q + 1'b1;
          end
        end
      end
    end
  end

  // Read-latency pipe. The last flag is decided at issue time and then
  // travels alongside the read, so the FIFO side never has to count beats.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pipe_v1_q <= 1'b0;
      pipe_v2_q <= 1'b0;
      last1_q   <= 1'b0;
      last2_q   <= 1'b0;
    end else begin
      pipe_v1_q <= issue;
      pipe_v2_q <= pipe_v1_q;
      last1_q   <= issue && issue_last;
      last2_q   <= last1_q;
    end
  end

  // Output FIFO
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_last[i] <= 1'b0;
      end
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr_q] <= r_data;
        fifo_last[wr_ptr_q] <= last2_q;
        wr_ptr_q            <= wr_ptr_q + 2'd1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 2'd1;
      end
      case ({push, pop})
        2'b10:   fifo_count_q <= fifo_count_q + 3'd1;
        2'b01:   fifo_count_q <= fifo_count_q - 3'd1;
        default: ;
      endcase
    end
  end

`ifdef LRELU_READER_USER_EN
  logic [USER_W-1:0] tag1_q, tag2_q;
  logic [USER_W-1:0] fifo_tag [FIFO_DEPTH];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      tag1_q <= '0;
      tag2_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_tag[i] <= '0;
      end
    end else begin
      tag1_q <= {clr_i_q, w_sel_q};
      tag2_q <= tag1_q;
      if (push) begin
        fifo_tag[wr_ptr_q] <= tag2_q;
      end
    end
  end

  assign m_user = fifo_tag[rd_ptr_q];
`else
  assign m_user = {USER_W{1'b0}};
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      done_q <= 1'b0;
    end else begin
      done_q <= pop && m_last;
    end
  end

  assign r_en    = issue;
  assign r_addr  = addr_q;
  assign m_valid = (fifo_count_q != 3'd0);
  assign m_data  = fifo_data[rd_ptr_q];
  assign m_last  = m_valid && fifo_last[rd_ptr_q];
  assign busy    = (state_q != IDLE);
  assign done    = done_q;

endmodule

// File: tb/tb_lrelu_config_reader.sv
// tb/tb_lrelu_config_reader.sv - scoreboard bench for lrelu_config_reader
module tb_lrelu_config_reader;

  localparam int MEMBERS      = 12;
  localparam int WORD_W       = 16;
  localparam int SEL_N        = 3;
  localparam int ADDR_PER_SEL = 4;
  localparam int CLR_I_MAX    = 1;
  localparam int DATA_W       = MEMBERS * WORD_W;
  localparam int ROWS         = (CLR_I_MAX + 1) * SEL_N * ADDR_PER_SEL;
  localparam int BITS_W_SEL   = 2;
  localparam int BUDGET       = 3000;
`ifdef LRELU_READER_USER_EN
  localparam bit USER_ON = 1'b1;
`else
  localparam bit USER_ON = 1'b0;
`endif

  logic              clk;
  logic              rstn;
  logic              full;
  logic              start;
  logic [0:0]        kw2;
  logic [15:0]       reps;
  logic              r_en;
  logic [4:0]        r_addr;
  logic [DATA_W-1:0] r_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic [2:0]        m_user;
  logic              m_last;
  logic              busy;
  logic              done;

  lrelu_config_reader dut (
    .clk     (clk),
    .rstn    (rstn),
    .full    (full),
    .start   (start),
    .kw2     (kw2),
    .reps    (reps),
    .r_en    (r_en),
    .r_addr  (r_addr),
    .r_data  (r_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_user  (m_user),
    .m_last  (m_last),
    .busy    (busy),
    .done    (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM model with a 2-cycle read latency
  logic [DATA_W-1:0] mem [ROWS];
  logic [DATA_W-1:0] ram_p1;
  always @(posedge clk) begin
    if (r_en) ram_p1 <= mem[r_addr];
    r_data <= ram_p1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int ready_pct = 100;
  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      m_ready = ($urandom_range(99) < ready_pct);
    end
  end

  // Scoreboard
  logic [DATA_W-1:0] exp_data [$];
  logic [2:0]        exp_user [$];
  logic              exp_last [$];
  int                exp_addr [$];

  int passed = 0;
  int total  = 0;

  int beats, exp_beats, first_ren, first_valid, last_hs;
  int issued, popped, max_out;
  bit done_seen, done_pending, stall_prev;
  logic [DATA_W-1:0] prev_data;
  logic [2:0]        prev_user;
  logic              prev_last;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [2:0] tag_of(input int idx);
    int clr, ws;
    clr = idx / (SEL_N * ADDR_PER_SEL);
    ws  = (idx / ADDR_PER_SEL) % SEL_N;
    return 3'((clr << BITS_W_SEL) | ws);
  endfunction

  // Monitor: samples on the falling edge, away from the active edge
  initial begin
    issued = 0; popped = 0; max_out = 0; beats = 0;
    done_seen = 0; done_pending = 0; stall_prev = 0;
    first_ren = -1; first_valid = -1; last_hs = 0;
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (r_en) begin
          chk("r_addr_expected", exp_addr.size() != 0, 1);
          if (exp_addr.size() != 0) chk("r_addr", r_addr, exp_addr.pop_front());
          if (first_ren < 0) first_ren = cyc;
          issued++;
          if (issued - popped > max_out) max_out = issued - popped;
        end
        if (m_valid && first_valid < 0) first_valid = cyc;
        if (stall_prev) begin
          chk("hold_valid", m_valid, 1);
          chk("hold_data", m_data, prev_data);
          chk("hold_user", m_user, prev_user);
          chk("hold_last", m_last, prev_last);
        end
        if (m_valid && m_ready) begin
          chk("beat_expected", exp_data.size() != 0, 1);
          if (exp_data.size() != 0) begin
            chk("m_data", m_data, exp_data.pop_front());
            chk("m_user", m_user, exp_user.pop_front());
            chk("m_last", m_last, exp_last.pop_front());
          end
          popped++;
          beats++;
          last_hs = cyc;
        end
        if (done_pending || done) chk("done_pulse", done, done_pending);
        if (done) done_seen = 1;
        done_pending = m_valid && m_ready && m_last;
        stall_prev   = m_valid && !m_ready;
        prev_data    = m_data;
        prev_user    = m_user;
        prev_last    = m_last;
      end
    end
  end

  task automatic check_reset(input string tagname);
    chk({tagname, "_r_en"},    r_en,    0);
    chk({tagname, "_r_addr"},  r_addr,  0);
    chk({tagname, "_m_valid"}, m_valid, 0);
    chk({tagname, "_m_data"},  m_data,  0);
    chk({tagname, "_m_user"},  m_user,  0);
    chk({tagname, "_m_last"},  m_last,  0);
    chk({tagname, "_busy"},    busy,    0);
    chk({tagname, "_done"},    done,    0);
  endtask

  // Loads fresh RAM contents, queues the expected response, starts a run
  task automatic launch(input int k, input int r, input int rdy, input bit spur);
    int kc, rc, n;
    kc = (k > CLR_I_MAX) ? CLR_I_MAX : k;
    rc = (r == 0) ? 1 : r;
    n  = (kc + 1) * SEL_N * ADDR_PER_SEL;
    for (int i = 0; i < ROWS; i++)
      mem[i] = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    for (int p = 0; p < rc; p++) begin
      for (int i = 0; i < n; i++) begin
        exp_data.push_back(mem[i]);
        exp_user.push_back(USER_ON ? tag_of(i) : 3'd0);
        exp_last.push_back((p == rc - 1) && (i == n - 1));
        exp_addr.push_back(i);
      end
    end
    exp_beats   = rc * n;
    beats       = 0;
    first_ren   = -1;
    first_valid = -1;
    done_seen   = 0;
    ready_pct   = rdy;
    start = 1'b1;
    full  = 1'b1;
    kw2   = 1'(k);
    reps  = 16'(r);
    @(posedge clk);
    #1;
    start = 1'b0;
    kw2   = 1'($urandom());
    reps  = 16'($urandom());
    full  = 1'($urandom());
    if (spur) begin
      repeat (4) @(posedge clk);
      #1;
      start = 1'b1;
      full  = 1'b1;
      kw2   = 1'b0;
      reps  = 16'd5;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
  endtask

  task automatic finish_run(input bit timing, input bit gapless);
    for (int c = 0; c < BUDGET && !done_seen; c++) @(posedge clk);
    #1;
    chk("done_seen", done_seen, 1);
    chk("beat_count", beats, exp_beats);
    chk("leftover_beats", exp_data.size(), 0);
    chk("leftover_addrs", exp_addr.size(), 0);
    if (timing) chk("first_valid_latency", first_valid - first_ren, 3);
    if (gapless) chk("no_gaps", last_hs - first_valid, exp_beats - 1);
    @(posedge clk);
    #1;
    chk("idle_after_done", busy, 0);
  endtask

  initial begin
    rstn  = 1'b0;
    full  = 1'b0;
    start = 1'b0;
    kw2   = 1'b0;
    reps  = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // start without a loaded table is ignored
    start = 1'b1;
    full  = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("gate_busy", busy, 0);
    chk("gate_r_en", r_en, 0);
    @(posedge clk);
    #1;
    chk("gate_busy_later", busy, 0);

    // basic run with a spurious start mid-run
    launch(1, 2, 100, 1'b1);
    finish_run(1'b1, 1'b1);

    // tag sequence, single replay
    launch(1, 1, 100, 1'b0);
    finish_run(1'b1, 1'b1);

    // backpressure at 30% ready
    launch(1, 3, 30, 1'b0);
    finish_run(1'b1, 1'b0);

    // kw2 above the maximum clamps; reps=0 means one replay
    launch(3, 0, 100, 1'b0);
    finish_run(1'b1, 1'b1);

    // kw2=0: 12 beats per replay, light backpressure
    launch(0, 2, 70, 1'b0);
    finish_run(1'b0, 1'b0);

    // reset mid-run aborts without done
    launch(1, 2, 100, 1'b0);
    for (int c = 0; c < 500 && beats < 10; c++) @(posedge clk);
    #1;
    chk("reached_10_beats", beats >= 10, 1);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    check_reset("midrun_reset");
    rstn = 1'b1;
    exp_data.delete();
    exp_user.delete();
    exp_last.delete();
    exp_addr.delete();
    issued = 0;
    popped = 0;
    done_pending = 0;
    stall_prev = 0;
    done_seen = 0;
    repeat (6) @(posedge clk);
    #1;
    chk("no_done_after_abort", done_seen, 0);

    // replay restarts from address 0 after the abort
    launch(1, 1, 100, 1'b0);
    finish_run(1'b1, 1'b1);

    chk("credit_limit", max_out <= 4, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
